piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in serial-out converter, the transmit-side counterpart to the team's parallel capture registers. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per beat on a serial valid/ready stream. Supports downstream backpressure and back-to-back words with no idle gap. Sits between a parallel data source and any serial consumer, such as a SIPO deserializer.

Parameters:
WIDTH, 4, word width in bits; legal values are WIDTH >= 2.
LSB_FIRST, 0, bit order: 0 sends in_data[WIDTH-1] first, 1 sends in_data[0] first.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  reset, synchronous, active-high.
in_data  input  WIDTH  parallel word to serialize.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a word this cycle (combinational).
ser_ready  input  1  downstream accepts the current bit.
ser_data  output  1  current serial bit (registered).
ser_valid  output  1  ser_data is valid (registered).
ser_last  output  1  current bit is the final bit of the word (registered).
busy  output  1  a word is in flight (state == SHIFT).
word_done  output  1  one-cycle pulse the cycle after the final bit transfers.

Behaviour:
- Word accept: occurs when in_valid && in_ready. in_data is sampled only on accept; changes at any other time are ignored.
- Bit transfer: occurs when ser_valid && ser_ready.
- Reset (rst=1 at a clock edge):
  - state=IDLE, shift register=0, bit counter=0.
  - ser_data=0, ser_valid=0, ser_last=0, busy=0, word_done=0.
  - in_ready is forced to 0 whenever rst=1.
  - Reset mid-word discards the word; no further bits of it are emitted.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, ser_valid=0, ser_data=0.
  - On accept: load the shift register, set counter=0, move to SHIFT.
- SHIFT:
  - ser_valid=1.
  - ser_data = shift register MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1).
  - ser_last=1 when counter == WIDTH-1.
- SHIFT, bit transfer with counter < WIDTH-1: shift by one toward the output end, counter+1.
- SHIFT, bit transfer with counter == WIDTH-1 (last bit):
  - word_done=1 on the next cycle.
  - If in_valid: accept the new word the same cycle, reload, counter=0, stay in SHIFT. There is no bubble.
  - Otherwise go to IDLE; ser_valid=0 on the next cycle.
- in_ready = (state==IDLE) || (state==SHIFT && ser_last && ser_ready), and 0 during rst.
- ser_ready=0 while ser_valid=1: ser_data, ser_last, the counter and the shift register all hold. No bit is dropped or duplicated.
- Latency: accept at edge N makes the first bit valid from cycle N+1. With ser_ready held at 1, the bits occupy cycles N+1..N+WIDTH and word_done asserts at N+WIDTH+1.
- Throughput: 1 bit/cycle sustained across back-to-back words.
- Counter width: $clog2(WIDTH).

Decomposition:
- Shared package piso_pkg: state encoding (IDLE=0, SHIFT=1) and a bit-order localparam helper, so a future sipo_deserializer uses the same order convention.
- No sub-module; the shift register, counter and FSM live in a single module.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> all outputs 0 and in_ready=0; after rst falls, in_ready=1 and no bit is emitted until an accept.
- Single word: WIDTH=4, LSB_FIRST=0, accept 4'b1010 at N, ser_ready=1 -> ser_data=1,0,1,0 on N+1..N+4; ser_last only at N+4; in_ready=1 at N+4; word_done at N+5; ser_valid=0 at N+5.
- Back-to-back: 4'b1010 then 4'b0011, in_valid held -> 8 contiguous bits 1,0,1,0,0,0,1,1; ser_valid never drops; word_done at N+5 and N+9.
- Backpressure: 4'b1100, ser_ready=0 for 3 cycles after the 2nd bit -> ser_data holds 0 with ser_valid=1; output sequence is exactly 1,1,0,0.
- Bit order: LSB_FIRST=1, accept 4'b1000 -> ser_data=0,0,0,1; also toggle in_data while busy -> no effect on output.
- Mid-word reset: rst pulsed after 2 bits of 4'b1111, then accept 4'b0110 -> stale bits do not resume; output is 0,1,1,0 with a single word_done.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial link blocks: FSM encoding and the bit-order
// convention, so serializer and deserializer always agree on which end goes first.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Index of the shift-register bit presented on the serial line.
  function automatic int unsigned out_bit_idx(input int unsigned width, input bit lsb_first);
    return lsb_first ? 0 : width - 1;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter: accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per beat, with backpressure and no gap between words.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy,
  output logic             word_done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam int            OUT_IDX  = out_bit_idx(WIDTH, LSB_FIRST != 0);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  piso_state_t      r_state, w_state_n;
  logic [WIDTH-1:0] r_shift, w_shift_n;
  logic [CW-1:0]    r_cnt, w_cnt_n, w_cnt_inc;
  logic             r_last, w_last_n;
  logic             r_done, w_done_n;
  logic             w_xfer;

  // Moves the next bit into the output position.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    if (LSB_FIRST != 0) return {1'b0, v[WIDTH-1:1]};
    else                return {v[WIDTH-2:0], 1'b0};
  endfunction

  assign ser_valid = (r_state == SHIFT);
  assign busy      = (r_state == SHIFT);
  assign ser_data  = r_shift[OUT_IDX];
  assign ser_last  = r_last;
  assign word_done = r_done;
  assign w_xfer    = ser_valid && ser_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  // r_last is only ever set in SHIFT, so it alone identifies the final beat.
  assign in_ready  = !rst && ((r_state == IDLE) || (r_last && ser_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_cnt   <= w_cnt_n;
      r_last  <= w_last_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_cnt_n   = r_cnt;
    w_last_n  = r_last;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_n = SHIFT;
          w_shift_n = in_data;
          w_cnt_n   = '0;
          w_last_n  = 1'b0;
        end
      end
      SHIFT: begin
        if (w_xfer) begin
          if (r_last) begin
            w_done_n = 1'b1;
            w_cnt_n  = '0;
            w_last_n = 1'b0;
            if (in_valid) begin
              w_shift_n = in_data;
            end else begin
              // Clearing the register keeps ser_data low while idle.
              w_state_n = IDLE;
              w_shift_n = '0;
            end
          end else begin
            w_shift_n = shift_out(r_shift);
            w_cnt_n   = w_cnt_inc;
            w_last_n  = (w_cnt_inc == LAST_CNT);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances share stimulus.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       ser_ready;

  logic in_ready0, ser_data0, ser_valid0, ser_last0, busy0, done0;
  logic in_ready1, ser_data1, ser_valid1, ser_last1, busy1, done1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .ser_ready(ser_ready), .ser_data(ser_data0), .ser_valid(ser_valid0),
    .ser_last(ser_last0), .busy(busy0), .word_done(done0)
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .ser_ready(ser_ready), .ser_data(ser_data1), .ser_valid(ser_valid1),
    .ser_last(ser_last1), .busy(busy1), .word_done(done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 4'b1111; ser_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready0 !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_ready actual=%b required=0", in_ready0);
    end
    step(); step();
    vectors++;
    if ({ser_data0, ser_valid0, ser_last0, busy0, done0, in_ready0} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs0 actual=%b required=000000",
               {ser_data0, ser_valid0, ser_last0, busy0, done0, in_ready0});
    end
    vectors++;
    if ({ser_data1, ser_valid1, ser_last1, busy1, done1, in_ready1} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs1 actual=%b required=000000",
               {ser_data1, ser_valid1, ser_last1, busy1, done1, in_ready1});
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready0 !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_in_ready actual=%b required=1", in_ready0);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if ({ser_valid0, ser_data0, busy0} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle_no_emit cyc=%0d actual=%b required=000", c, {ser_valid0, ser_data0, busy0});
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] w;
    w = 4'b1010;
    in_data = w; in_valid = 1'b1; ser_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({ser_valid0, ser_data0, ser_last0, done0} !== {1'b1, w[3-k], (k == 3), 1'b0}) begin
        miscompares++;
        $display("FAIL single_bit%0d actual(v,d,l,done)=%b required=%b", k,
                 {ser_valid0, ser_data0, ser_last0, done0}, {1'b1, w[3-k], (k == 3), 1'b0});
      end
      if (k == 3) begin
        vectors++;
        if (in_ready0 !== 1'b1) begin
          miscompares++; $display("FAIL single_ready_on_last actual=%b required=1", in_ready0);
        end
      end
      step();
    end
    vectors++;
    if ({done0, ser_valid0, busy0} !== 3'b100) begin
      miscompares++;
      $display("FAIL single_done actual(done,v,busy)=%b required=100", {done0, ser_valid0, busy0});
    end
    step();
    vectors++;
    if (done0 !== 1'b0) begin
      miscompares++; $display("FAIL single_done_pulse actual=%b required=0", done0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    seq = 8'b1010_0011;
    in_data = 4'b1010; in_valid = 1'b1; ser_ready = 1'b1;
    step();
    in_data = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) in_valid = 1'b0;
      vectors++;
      if ({ser_valid0, ser_data0, done0} !== {1'b1, seq[7-k], (k == 4)}) begin
        miscompares++;
        $display("FAIL b2b_bit%0d actual(v,d,done)=%b required=%b", k,
                 {ser_valid0, ser_data0, done0}, {1'b1, seq[7-k], (k == 4)});
      end
      step();
    end
    vectors++;
    if ({done0, ser_valid0} !== 2'b10) begin
      miscompares++; $display("FAIL b2b_second_done actual(done,v)=%b required=10", {done0, ser_valid0});
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] got;
    int         got_n;
    got = '0; got_n = 0;
    in_data = 4'b1100; in_valid = 1'b1; ser_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 12 && got_n < 4; c++) begin
      ser_ready = !(c >= 2 && c <= 4);
      if (c >= 2 && c <= 4) begin
        vectors++;
        if ({ser_valid0, ser_data0, ser_last0} !== 3'b100) begin
          miscompares++;
          $display("FAIL bp_hold cyc=%0d actual(v,d,l)=%b required=100", c, {ser_valid0, ser_data0, ser_last0});
        end
      end
      if (ser_valid0 && ser_ready) begin
        got[3-got_n] = ser_data0;
        got_n++;
      end
      step();
    end
    ser_ready = 1'b1;
    vectors++;
    if (got !== 4'b1100 || got_n != 4) begin
      miscompares++; $display("FAIL bp_sequence actual=%b n=%0d required=1100 n=4", got, got_n);
    end
    vectors++;
    if ({done0, ser_valid0} !== 2'b10) begin
      miscompares++; $display("FAIL bp_done actual(done,v)=%b required=10", {done0, ser_valid0});
    end
  endtask

  task automatic test_bit_order();
    logic [3:0] e0, e1;
    e0 = 4'b1000;
    e1 = 4'b1000;
    in_data = 4'b1000; in_valid = 1'b1; ser_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_data = ~in_data;
      vectors++;
      if ({ser_valid1, ser_data1, ser_last1} !== {1'b1, e1[k], (k == 3)}) begin
        miscompares++;
        $display("FAIL lsb_first_bit%0d actual(v,d,l)=%b required=%b", k,
                 {ser_valid1, ser_data1, ser_last1}, {1'b1, e1[k], (k == 3)});
      end
      vectors++;
      if (ser_data0 !== e0[3-k]) begin
        miscompares++; $display("FAIL msb_first_bit%0d actual=%b required=%b", k, ser_data0, e0[3-k]);
      end
      step();
    end
    vectors++;
    if ({done1, ser_valid1, ser_valid0} !== 3'b100) begin
      miscompares++;
      $display("FAIL order_done actual(done1,v1,v0)=%b required=100", {done1, ser_valid1, ser_valid0});
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] got;
    int         got_n;
    int         dones;
    got = '0; got_n = 0; dones = 0;
    in_data = 4'b1111; in_valid = 1'b1; ser_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready0 !== 1'b0) begin
      miscompares++; $display("FAIL midrst_in_ready actual=%b required=0", in_ready0);
    end
    step();
    vectors++;
    if ({ser_valid0, ser_data0, ser_last0, busy0, done0} !== 5'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs actual=%b required=00000", {ser_valid0, ser_data0, ser_last0, busy0, done0});
    end
    rst = 1'b0;
    in_data = 4'b0110; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (ser_valid0 && ser_ready && got_n < 4) begin
        got[3-got_n] = ser_data0;
        got_n++;
      end
      if (done0) dones++;
      step();
    end
    vectors++;
    if (got !== 4'b0110 || got_n != 4) begin
      miscompares++; $display("FAIL midrst_sequence actual=%b n=%0d required=0110 n=4", got, got_n);
    end
    vectors++;
    if (dones != 1) begin
      miscompares++; $display("FAIL midrst_done_count actual=%0d required=1", dones);
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; ser_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_bit_order();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
